// File: rtl/mem_port_a_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_a_responder_if : control-unit request bus plus block-RAM port   |
// | for the memory port A responder; range_err exists with MEMA_RANGE_CHECK_EN|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mem_port_a_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              memAEnabled;
  logic              memAWriteEnabled;
  logic              memWriteOrRead;
  logic [ADDR_W-1:0] pcAddress;
  logic [ADDR_W-1:0] regAddress;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] readData;
  logic              done;
  logic              busy;
  logic              dropped;
`ifdef MEMA_RANGE_CHECK_EN
  logic              range_err;
`endif
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // master = control unit together with the RAM it shares the bus with
  modport master (
    output memAEnabled, memAWriteEnabled, memWriteOrRead,
    output pcAddress, regAddress, writeData, ram_rdata,
    input  instruction, readData, done, busy, dropped,
`ifdef MEMA_RANGE_CHECK_EN
    input  range_err,
`endif
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  memAEnabled, memAWriteEnabled, memWriteOrRead,
    input  pcAddress, regAddress, writeData, ram_rdata,
    output instruction, readData, done, busy, dropped,
`ifdef MEMA_RANGE_CHECK_EN
    output range_err,
`endif
    output ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_a_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_a_responder : one-at-a-time fetch/load/store responder driving a|
// | fixed-latency sync RAM. Optional macro MEMA_RANGE_CHECK_EN bounds-checks.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_a_responder #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 2,
  parameter int MEM_DEPTH    = 65536
) (
  input  wire logic             clock,
  input  wire logic             reset,
  mem_port_a_responder_if.slave bus
);

  if (READ_LATENCY < 1 || READ_LATENCY > 7 || MEM_DEPTH < 1) begin : g_bad_params
    $error("mem_port_a_responder: READ_LATENCY must be 1..7 and MEM_DEPTH positive");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_e;
  typedef enum logic [1:0] {K_FETCH = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2} kind_e;

  localparam logic [2:0] c_LAT_M1 = 3'(READ_LATENCY - 1);

  state_e            state_q;
  kind_e             kind_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;
  logic              busy_q;
  logic              drop_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] w_addr;
  kind_e             w_kind;

  // A write strobe with the PC selected is still a fetch.
  assign w_addr = bus.memWriteOrRead ? bus.regAddress : bus.pcAddress;
  assign w_kind = !bus.memWriteOrRead ? K_FETCH :
                  (bus.memAWriteEnabled ? K_STORE : K_LOAD);

`ifdef MEMA_RANGE_CHECK_EN
  logic range_err_q;
  logic w_oor;
  assign w_oor         = ({1'b0, w_addr} >= (ADDR_W + 1)'(MEM_DEPTH));
  assign bus.range_err = range_err_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_FETCH;
      cnt_q    <= '0;
      instr_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef MEMA_RANGE_CHECK_EN
      range_err_q <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
`ifdef MEMA_RANGE_CHECK_EN
      range_err_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (bus.memAEnabled) begin
            kind_q  <= w_kind;
            addr_q  <= w_addr;
            wdata_q <= bus.writeData;
            busy_q  <= 1'b1;
`ifdef MEMA_RANGE_CHECK_EN
            if (w_oor) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              range_err_q <= 1'b1;
              if (w_kind == K_FETCH) instr_q <= '0;
              if (w_kind == K_LOAD)  rdata_q <= '0;
            end else begin
              state_q  <= S_ISSUE;
              ram_en_q <= 1'b1;
              ram_we_q <= (w_kind == K_STORE);
            end
`else
            state_q  <= S_ISSUE;
            ram_en_q <= 1'b1;
            ram_we_q <= (w_kind == K_STORE);
`endif
          end
        end
        S_ISSUE: begin
          if (kind_q == K_STORE) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= c_LAT_M1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // cnt_q reaches zero exactly when ram_rdata carries the addressed word
          if (cnt_q == 3'd0) begin
            if (kind_q == K_FETCH) instr_q <= bus.ram_rdata;
            else                   rdata_q <= bus.ram_rdata;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (bus.memAEnabled && (state_q != S_IDLE)) drop_q <= 1'b1;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.readData    = rdata_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.dropped     = drop_q;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wdata   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_a_responder.sv
`default_nettype none
// tb_mem_port_a_responder: responders with READ_LATENCY 2/1/7 on behavioural RAMs,
// directed and randomized requests checked against an address-map reference model.
module tb_mem_port_a_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [2:0]  en_v = '0, we_v = '0, wor_v = '0;
  logic [15:0] pca_a [3];
  logic [15:0] rga_a [3];
  logic [15:0] wd_a  [3];
  logic [2:0]  done_v, busy_v, drop_v, ren_v, rwe_v;
  logic [15:0] instr_a [3];
  logic [15:0] rdat_a  [3];
  logic [15:0] raddr_a [3];
  logic [15:0] rwd_a   [3];
`ifdef MEMA_RANGE_CHECK_EN
  logic [2:0]  rerr_v;
`endif

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 2 : ((k == 1) ? 1 : 7);
    mem_port_a_responder_if #(.ADDR_W(16), .DATA_W(16)) u_bus ();
    logic [15:0] ram  [65536];
    logic [15:0] pipe [7];

    assign u_bus.memAEnabled      = en_v[k];
    assign u_bus.memAWriteEnabled = we_v[k];
    assign u_bus.memWriteOrRead   = wor_v[k];
    assign u_bus.pcAddress        = pca_a[k];
    assign u_bus.regAddress       = rga_a[k];
    assign u_bus.writeData        = wd_a[k];
    assign u_bus.ram_rdata        = pipe[LAT-1];
    assign done_v[k]  = u_bus.done;
    assign busy_v[k]  = u_bus.busy;
    assign drop_v[k]  = u_bus.dropped;
    assign ren_v[k]   = u_bus.ram_en;
    assign rwe_v[k]   = u_bus.ram_we;
    assign instr_a[k] = u_bus.instruction;
    assign rdat_a[k]  = u_bus.readData;
    assign raddr_a[k] = u_bus.ram_addr;
    assign rwd_a[k]   = u_bus.ram_wdata;
`ifdef MEMA_RANGE_CHECK_EN
    assign rerr_v[k]  = u_bus.range_err;
`endif

    // Read data is valid exactly LAT cycles after ram_en; garbage otherwise.
    always @(posedge clock) begin
      if (u_bus.ram_en && u_bus.ram_we) ram[u_bus.ram_addr] <= u_bus.ram_wdata;
      pipe[0] <= (u_bus.ram_en && !u_bus.ram_we) ? ram[u_bus.ram_addr] : 16'($urandom);
      for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end

    mem_port_a_responder #(
      .READ_LATENCY(LAT)
`ifdef MEMA_RANGE_CHECK_EN
      , .MEM_DEPTH(1024)
`endif
    ) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (u_bus)
    );
  end

  // Reference model: word map keyed by dut*65536+addr, expected held registers.
  logic [15:0] mm [int];
  logic [15:0] exp_instr [3];
  logic [15:0] exp_rdata [3];
  logic [2:0]  exp_drop;
  logic [15:0] wq [$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 fetch with write strobe set
  task automatic run_req(input int k, input int kind, input logic [15:0] addr,
                         input logic [15:0] wd, input bit ovl);
    int lat, nen, nwe, e_lat, key;
    bit got, bad_bus, busy_bad, is_store;
    is_store = (kind == 2);
    key      = k * 65536 + int'(addr);
    e_lat    = is_store ? 2 : lat_of(k) + 2;
    @(negedge clock);
    en_v[k]  = 1'b1;
    we_v[k]  = (kind >= 2);
    wor_v[k] = (kind == 1 || kind == 2);
    pca_a[k] = wor_v[k] ? 16'($urandom) : addr;
    rga_a[k] = wor_v[k] ? addr : 16'($urandom);
    wd_a[k]  = wd;
    got = 0; lat = 0; nen = 0; nwe = 0; bad_bus = 0; busy_bad = 0;
    for (int c = 1; c <= 24 && !got; c++) begin
      @(negedge clock);
      if (ren_v[k]) begin
        nen++;
        if (raddr_a[k] !== addr || (is_store && rwd_a[k] !== wd)) bad_bus = 1;
      end
      if (rwe_v[k]) nwe++;
      if (!busy_v[k]) busy_bad = 1;
      if (done_v[k]) begin
        got = 1;
        lat = c;
      end else begin
        en_v[k] = ovl && (c == 2);
        if (c == 1) begin
          we_v[k]  = 1'($urandom);
          wor_v[k] = 1'($urandom);
          pca_a[k] = 16'($urandom);
          rga_a[k] = 16'($urandom);
          wd_a[k]  = 16'($urandom);
        end
      end
    end
    en_v[k] = 1'b0;
    if (is_store) mm[key] = wd;
    else if (kind == 1) exp_rdata[k] = mm[key];
    else exp_instr[k] = mm[key];
    if (ovl) exp_drop[k] = 1'b1;
    check($sformatf("k%0d_done_seen", k), 64'(got), 64'd1);
    check($sformatf("k%0d_latency", k), 64'(lat), 64'(e_lat));
    check($sformatf("k%0d_ram_en_cycles", k), 64'(nen), 64'd1);
    check($sformatf("k%0d_ram_we_cycles", k), 64'(nwe), 64'(is_store));
    check($sformatf("k%0d_ram_addr_wdata", k), 64'(bad_bus), 64'd0);
    check($sformatf("k%0d_busy_through_done", k), 64'(busy_bad), 64'd0);
    check($sformatf("k%0d_instruction", k), 64'(instr_a[k]), 64'(exp_instr[k]));
    check($sformatf("k%0d_readData", k), 64'(rdat_a[k]), 64'(exp_rdata[k]));
    check($sformatf("k%0d_dropped", k), 64'(drop_v[k]), 64'(exp_drop[k]));
    @(negedge clock);
    check($sformatf("k%0d_single_done_idle", k), {62'd0, done_v[k], busy_v[k]}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, cnt;
    logic [15:0] a;
    for (int k = 0; k < 3; k++) begin
      pca_a[k] = '0; rga_a[k] = '0; wd_a[k] = '0;
      exp_instr[k] = '0; exp_rdata[k] = '0;
    end
    exp_drop = '0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("k%0d_reset_data", k), {instr_a[k], rdat_a[k], raddr_a[k], rwd_a[k]}, 64'd0);
      check($sformatf("k%0d_reset_ctrl", k),
            {59'd0, done_v[k], busy_v[k], drop_v[k], ren_v[k], rwe_v[k]}, 64'd0);
    end
    reset = 1'b1;

    // Directed: preload, fetch 0x10, store/load 0x200, busy overlap during WAIT
    run_req(0, 2, 16'h0010, 16'h5A21, 0);
    run_req(0, 0, 16'h0010, 16'h0000, 0);
    run_req(0, 2, 16'h0200, 16'hBEEF, 0);
    run_req(0, 1, 16'h0200, 16'h0000, 0);
    run_req(0, 1, 16'h0010, 16'h0000, 1);
    run_req(0, 3, 16'h0200, 16'h7777, 0);
    wq.push_back(16'h0010);
    wq.push_back(16'h0200);

    // Async reset in WAIT of a load
    @(negedge clock);
    en_v[0] = 1'b1; we_v[0] = 1'b0; wor_v[0] = 1'b1; rga_a[0] = 16'h0200;
    @(negedge clock);
    en_v[0] = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("reset_mid_data", {instr_a[0], rdat_a[0], raddr_a[0], rwd_a[0]}, 64'd0);
    check("reset_mid_ctrl", {59'd0, done_v[0], busy_v[0], drop_v[0], ren_v[0], rwe_v[0]}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_instr[k] = '0; exp_rdata[k] = '0;
    end
    exp_drop = '0;
    cnt = 0;
    repeat (6) begin
      @(negedge clock);
      if (done_v[0]) cnt++;
    end
    check("no_done_after_reset", 64'(cnt), 64'd0);
    run_req(0, 0, 16'h0010, 16'h0000, 0);

    // Randomized traffic on the latency-2 responder
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      if (kind == 2) begin
        a = 16'($urandom) & 16'h03FF;
        wq.push_back(a);
      end else begin
        a = wq[$urandom_range(0, wq.size() - 1)];
      end
      run_req(0, kind, a, 16'($urandom), (kind != 2) && ($urandom_range(0, 3) == 0));
    end

    // Latency sweep: READ_LATENCY 1 and 7
    for (int k = 1; k < 3; k++) begin
      a = 16'($urandom) & 16'h03FF;
      run_req(k, 2, a, 16'($urandom), 0);
      run_req(k, 1, a, 16'h0000, 0);
      run_req(k, 0, a, 16'h0000, 1);
    end

`ifdef MEMA_RANGE_CHECK_EN
    begin
      int nen, lat;
      bit rerr_ok;
      @(negedge clock);
      en_v[0] = 1'b1; we_v[0] = 1'b0; wor_v[0] = 1'b1; rga_a[0] = 16'h0400;
      nen = 0; lat = 0; rerr_ok = 0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clock);
        en_v[0] = 1'b0;
        if (ren_v[0]) nen++;
        if (done_v[0] && lat == 0) begin
          lat = c;
          rerr_ok = rerr_v[0];
        end
      end
      exp_rdata[0] = '0;
      check("range_no_ram_en", 64'(nen), 64'd0);
      check("range_latency", 64'(lat), 64'd1);
      check("range_err_with_done", 64'(rerr_ok), 64'd1);
      check("range_readData", 64'(rdat_a[0]), 64'(exp_rdata[0]));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
